// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared constants for the DMA command front-end: default field widths,
// the two legal transfer modes, FSM state encodings and a helper that
// computes the packed descriptor width.
// No ports (package).
// -----------------------------------------------------------------------------
package dma_pkg;

  localparam int DMA_ADDR_WIDTH  = 12;
  localparam int DMA_SIZE_WIDTH  = 8;
  localparam int DMA_MODE_WIDTH  = 4;
  localparam int DMA_FIFO_DEPTH  = 4;
  localparam int DMA_WDOG_CYCLES = 256;

  localparam logic [3:0] DMA_MODE_LOAD  = 4'b0001;
  localparam logic [3:0] DMA_MODE_STORE = 4'b0010;

  // FSM encodings kept as plain constants so older tools and dumps read them
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Descriptor is packed as {addr, size, mode}
  function automatic int dma_desc_width(input int aw, input int sw, input int mw);
    return aw + sw + mw;
  endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// -----------------------------------------------------------------------------
// dma_cmd_fifo
// Synchronous FIFO holding packed DMA descriptors. The head entry is always
// visible on pop_data; a pop simply advances the read pointer.
// Ports:
//   clk, rst    clock and synchronous active-high reset (flushes the FIFO)
//   push        write push_data (ignored when full)
//   push_data   descriptor to store
//   pop         discard the head entry (ignored when empty)
//   pop_data    head entry
//   full/empty  occupancy flags
//   count       number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module dma_cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; the pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_cmd_queue.sv
// -----------------------------------------------------------------------------
// dma_cmd_queue
// Command front-end for dma_load_store. The core writes descriptors
// (addr, size, mode); illegal ones (size 0, or mode other than load/store)
// are swallowed with an err_pulse. Legal ones are queued and issued one at a
// time: the request is held on dma_valid until the engine has returned exactly
// dma_size beats, then done_pulse fires and the next descriptor is issued.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       descriptor handshake from the core
//   cmd_addr/size/mode        descriptor fields
//   dma_valid                 request level to the engine
//   dma_addr/size/mode        fields of the request in flight
//   dma_beat                  one pulse per word transferred by the engine
//   busy                      transfer in flight or descriptors queued
//   done_pulse                one cycle when a transfer completes
//   err_pulse                 one cycle on a rejected descriptor or timeout
//   q_count                   descriptors waiting in the FIFO
// Build option:
//   DMA_CMD_WDOG_EN  when defined, a beat-gap watchdog aborts a transfer that
//                    sees no beat for WDOG_CYCLES cycles (err_pulse, no done).
// -----------------------------------------------------------------------------
module dma_cmd_queue
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH  = DMA_ADDR_WIDTH,
  parameter int SIZE_WIDTH  = DMA_SIZE_WIDTH,
  parameter int MODE_WIDTH  = DMA_MODE_WIDTH,
  parameter int DEPTH       = DMA_FIFO_DEPTH,
  parameter int WDOG_CYCLES = DMA_WDOG_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [SIZE_WIDTH-1:0]        cmd_size,
  input  logic [MODE_WIDTH-1:0]        cmd_mode,
  output logic                         dma_valid,
  output logic [ADDR_WIDTH-1:0]        dma_addr,
  output logic [SIZE_WIDTH-1:0]        dma_size,
  output logic [MODE_WIDTH-1:0]        dma_mode,
  input  logic                         dma_beat,
  output logic                         busy,
  output logic                         done_pulse,
  output logic                         err_pulse,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int DESC_W = dma_desc_width(ADDR_WIDTH, SIZE_WIDTH, MODE_WIDTH);

  logic [1:0]            state;
  logic [SIZE_WIDTH-1:0] beat_cnt;
  logic [SIZE_WIDTH-1:0] last_beat;
  logic                  cmd_hs;
  logic                  desc_ok;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DESC_W-1:0]     fifo_head;
  logic                  wdog_timeout;

  // A rejected descriptor still completes the handshake so the core moves on
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign desc_ok   = (cmd_size != '0) &&
                     ((cmd_mode == MODE_WIDTH'(DMA_MODE_LOAD)) ||
                      (cmd_mode == MODE_WIDTH'(DMA_MODE_STORE)));
  assign fifo_push = cmd_hs & desc_ok;
  assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty;
  assign cmd_ready = ~fifo_full;
  assign busy      = (state != ST_IDLE) | (q_count != '0);

  // Wraps to all-ones for size 0, but size 0 never reaches the FIFO
  assign last_beat = dma_size - SIZE_WIDTH'(1);

  dma_cmd_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({cmd_addr, cmd_size, cmd_mode}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (q_count)
  );

`ifdef DMA_CMD_WDOG_EN
  localparam int GAP_W = $clog2(WDOG_CYCLES);

  logic [GAP_W-1:0] gap_cnt;

  // Gap counter only runs while waiting for beats; every beat restarts it
  always_ff @(posedge clk) begin
    if (rst || (state != ST_WAIT) || dma_beat) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  assign wdog_timeout = (state == ST_WAIT) && !dma_beat &&
                        (gap_cnt == GAP_W'(WDOG_CYCLES - 1));
`else
  // Without the watchdog a transfer waits forever; the expression is
  // constant false and only keeps the parameter referenced
  assign wdog_timeout = (WDOG_CYCLES < 0);
`endif

  // Issue FSM. dma_valid, done_pulse and err_pulse are registered so the
  // engine sees glitch-free levels; DONE forces at least one low cycle on
  // dma_valid between consecutive requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dma_valid  <= 1'b0;
      dma_addr   <= '0;
      dma_size   <= '0;
      dma_mode   <= '0;
      beat_cnt   <= '0;
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      err_pulse  <= cmd_hs & ~desc_ok;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {dma_addr, dma_size, dma_mode} <= fifo_head;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          dma_valid <= 1'b1;
          beat_cnt  <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dma_beat) begin
            if (beat_cnt == last_beat) begin
              dma_valid  <= 1'b0;
              done_pulse <= 1'b1;
              state      <= ST_DONE;
            end else begin
              beat_cnt <= beat_cnt + SIZE_WIDTH'(1);
            end
          end else if (wdog_timeout) begin
            dma_valid <= 1'b0;
            err_pulse <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_dma_cmd_queue
// Directed self-checking bench for dma_cmd_queue. Inputs are driven and
// outputs sampled 1 time unit after each rising edge. Expected values are
// hand-derived cycle counts and descriptor fields.
// -----------------------------------------------------------------------------
module tb_dma_cmd_queue;

  localparam int AW = 12;
  localparam int SW = 8;
  localparam int MW = 4;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [SW-1:0] cmd_size;
  logic [MW-1:0] cmd_mode;
  logic          dma_valid;
  logic [AW-1:0] dma_addr;
  logic [SW-1:0] dma_size;
  logic [MW-1:0] dma_mode;
  logic          dma_beat;
  logic          busy;
  logic          done_pulse;
  logic          err_pulse;
  logic [CW-1:0] q_count;

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  dma_cmd_queue #(
    .ADDR_WIDTH  (AW),
    .SIZE_WIDTH  (SW),
    .MODE_WIDTH  (MW),
    .DEPTH       (DEPTH),
    .WDOG_CYCLES (256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_size   (cmd_size),
    .cmd_mode   (cmd_mode),
    .dma_valid  (dma_valid),
    .dma_addr   (dma_addr),
    .dma_size   (dma_size),
    .dma_mode   (dma_mode),
    .dma_beat   (dma_beat),
    .busy       (busy),
    .done_pulse (done_pulse),
    .err_pulse  (err_pulse),
    .q_count    (q_count)
  );

  // Pulse counters sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (done_pulse) done_count++;
      if (err_pulse)  err_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a,
                               input logic [SW-1:0] s, input logic [MW-1:0] m);
    cmd_valid = v;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_mode  = m;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int base_done;
  int base_err;
  int lows;
  int waited;
  logic rdy [6];

  initial begin
    rst = 1'b1;
    dma_beat = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    step();
    step();

    // ---- reset state ----
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_dma_valid", dma_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_q_count", q_count, 0);
    checkOutput("rst_done", done_pulse, 0);
    checkOutput("rst_err", err_pulse, 0);
    checkOutput("rst_dma_fields", {dma_addr, dma_size, dma_mode}, 0);
    rst = 1'b0;
    step();

    // ---- single transfer: 100h, 8 beats, load ----
    $display("[TB] single transfer");
    base_done = done_count;
    applyStimulus(1'b1, 12'h100, 8'd8, 4'b0001);
    checkOutput("t1_ready", cmd_ready, 1);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("t1_q_count_n1", q_count, 1);
    checkOutput("t1_valid_n1", dma_valid, 0);
    checkOutput("t1_busy_n1", busy, 1);
    step();
    checkOutput("t1_valid_n2", dma_valid, 0);
    step();
    checkOutput("t1_valid_n3", dma_valid, 1);
    for (int i = 0; i < 8; i++) begin
      dma_beat = 1'b1;
      checkOutput($sformatf("t1_fields_b%0d", i), {dma_valid, dma_addr, dma_size, dma_mode},
                  {1'b1, 12'h100, 8'd8, 4'b0001});
      checkOutput($sformatf("t1_nodone_b%0d", i), done_pulse, 0);
      step();
    end
    dma_beat = 1'b0;
    checkOutput("t1_done", done_pulse, 1);
    checkOutput("t1_valid_low", dma_valid, 0);
    step();
    checkOutput("t1_done_once", done_pulse, 0);
    checkOutput("t1_idle_busy", busy, 0);
    checkOutput("t1_done_count", done_count - base_done, 1);

    // ---- fill the queue with no beats ----
    // The first descriptor leaves the FIFO the cycle after it lands, so
    // five offers in a row fit and the sixth sees cmd_ready low.
    $display("[TB] queue fill");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, AW'(12'h10 + i), 8'd2, 4'b0001);
      rdy[i] = cmd_ready;
      step();
    end
    applyStimulus(1'b0, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t2_ready_%0d", i), rdy[i], 1);
    end
    checkOutput("t2_ready_full", rdy[5], 0);
    checkOutput("t2_q_count", q_count, 4);
    checkOutput("t2_ready_now", cmd_ready, 0);
    checkOutput("t2_inflight", {dma_valid, dma_addr}, {1'b1, 12'h010});
    pulseReset();
    checkOutput("t2_flush_q", q_count, 0);
    checkOutput("t2_flush_valid", dma_valid, 0);
    step();

    // ---- rejected descriptors ----
    $display("[TB] rejects");
    base_err = err_count;
    applyStimulus(1'b1, 12'h200, 8'd0, 4'b0010);
    step();
    applyStimulus(1'b1, 12'h300, 8'd4, 4'b0111);
    checkOutput("t3_err1", err_pulse, 1);
    checkOutput("t3_q1", q_count, 0);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("t3_err2", err_pulse, 1);
    checkOutput("t3_q2", q_count, 0);
    step();
    checkOutput("t3_err_end", err_pulse, 0);
    checkOutput("t3_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t3_novalid_%0d", i), dma_valid, 0);
      step();
    end
    checkOutput("t3_err_count", err_count - base_err, 2);

    // ---- back-to-back descriptors ----
    // done_pulse lands one cycle after the last beat and the next request
    // rises three cycles after done_pulse, giving three low cycles.
    $display("[TB] back-to-back");
    base_done = done_count;
    applyStimulus(1'b1, 12'h200, 8'd4, 4'b0010);
    step();
    applyStimulus(1'b1, 12'h210, 8'd1, 4'b0001);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    step();
    checkOutput("t4_req1", {dma_valid, dma_addr, dma_size, dma_mode},
                {1'b1, 12'h200, 8'd4, 4'b0010});
    for (int i = 0; i < 4; i++) begin
      dma_beat = 1'b1;
      step();
    end
    dma_beat = 1'b0;
    checkOutput("t4_done1", done_pulse, 1);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      if (dma_valid) break;
      lows++;
      step();
    end
    checkOutput("t4_low_gap", lows, 3);
    checkOutput("t4_req2", {dma_valid, dma_addr, dma_size, dma_mode},
                {1'b1, 12'h210, 8'd1, 4'b0001});
    dma_beat = 1'b1;
    step();
    dma_beat = 1'b0;
    checkOutput("t4_done2", done_pulse, 1);
    step();
    checkOutput("t4_done_count", done_count - base_done, 2);

    // ---- reset in the middle of a transfer ----
    $display("[TB] mid-transfer reset");
    base_done = done_count;
    applyStimulus(1'b1, 12'h100, 8'd8, 4'b0001);
    step();
    applyStimulus(1'b1, 12'h120, 8'd2, 4'b0010);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    step();
    for (int i = 0; i < 3; i++) begin
      dma_beat = 1'b1;
      step();
    end
    dma_beat = 1'b0;
    checkOutput("t5_pre_valid", dma_valid, 1);
    checkOutput("t5_pre_q", q_count, 1);
    pulseReset();
    checkOutput("t5_valid", dma_valid, 0);
    checkOutput("t5_q", q_count, 0);
    checkOutput("t5_done", done_pulse, 0);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_ready", cmd_ready, 1);
    step();
    checkOutput("t5_done_after", done_pulse, 0);
    checkOutput("t5_done_count", done_count - base_done, 0);

`ifdef DMA_CMD_WDOG_EN
    // ---- watchdog: stall after two beats ----
    $display("[TB] watchdog");
    applyStimulus(1'b1, 12'h400, 8'd4, 4'b0001);
    step();
    applyStimulus(1'b1, 12'h410, 8'd1, 4'b0010);
    step();
    applyStimulus(1'b0, '0, '0, '0);
    step();
    for (int i = 0; i < 2; i++) begin
      dma_beat = 1'b1;
      step();
    end
    dma_beat = 1'b0;
    waited = 1;
    while (!err_pulse && waited < 400) begin
      step();
      waited++;
    end
    checkOutput("t6_gap", waited, 257);
    checkOutput("t6_valid_drop", dma_valid, 0);
    checkOutput("t6_no_done", done_pulse, 0);
    step();
    step();
    step();
    checkOutput("t6_next", {dma_valid, dma_addr}, {1'b1, 12'h410});
    dma_beat = 1'b1;
    step();
    dma_beat = 1'b0;
    checkOutput("t6_next_done", done_pulse, 1);
    step();
`else
    waited = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
